char_buffer: RTL

Character-cell text buffer that sits in front of the glyph renderer in the IO_graphics path. Its write side accepts ASCII characters from the calculator/keyboard logic over a valid/ready handshake, and it manages a cursor with wrap, newline, backspace and clear. Its read side converts the current pixel coordinate into the 7-bit character code for that 16×16 cell. The renderer then draws that code.

---
 rtl/char_buffer_pkg.sv | 25 ++
 rtl/char_ram.sv | 39 +++
 rtl/char_buffer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/char_buffer_pkg.sv
// Shared constants, FSM state type and sizing helper for the character buffer.
package char_buffer_pkg;

    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [6:0] ASCII_CR    = 7'h0D;
    localparam logic [6:0] ASCII_LF    = 7'h0A;
    localparam logic [6:0] ASCII_BS    = 7'h08;
    localparam logic [6:0] ASCII_FF    = 7'h0C;
    localparam logic [6:0] ASCII_TILDE = 7'h7E;

    localparam int unsigned GLYPH_SIZE = 16;
    localparam int unsigned GLYPH_LOG2 = 4;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        IDLE    = 2'd1,
        ROW_CLR = 2'd2
    } state_e;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/char_ram.sv
// Simple dual-port character RAM: synchronous write, registered read-first read.
module char_ram
    import char_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 1200,
    parameter int unsigned WIDTH  = 7,
    parameter int unsigned ADDR_W = width_of(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              rd_clr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register; sees the pre-write contents when addresses collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_clr) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/char_buffer.sv
// Character-cell text buffer: cursor-managed write side, pixel-addressed read side.
// Optional cursor blink is built when CURSOR_BLINK_EN is defined.
module char_buffer
    import char_buffer_pkg::*;
#(
    parameter int unsigned COLS         = 40,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned BLINK_CYCLES = 32_500_000
) (
    input  logic        pix_clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [6:0]  i_char,
    output logic        o_ready,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    output logic [6:0]  o_character,
    output logic        o_cursor
);

    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned ADDR_W = width_of(CELLS);
    localparam int unsigned COL_W  = width_of(COLS);
    localparam int unsigned ROW_W  = width_of(ROWS);
    localparam int unsigned CNT_W  = ADDR_W;

    state_e             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [ROW_W-1:0]   cur_row, cur_row_d, row_inc;
    logic [COL_W-1:0]   cur_col, cur_col_d;
    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [6:0]         wdata;

    logic [11:0]        col_rd, row_rd;
    logic               rd_in_range;
    logic [ADDR_W-1:0]  rd_addr;

    function automatic logic [ADDR_W-1:0] cell_addr(input int unsigned r, input int unsigned c);
        return ADDR_W'(r * COLS + c);
    endfunction

    assign row_inc = (cur_row == ROW_W'(ROWS - 1)) ? '0 : cur_row + ROW_W'(1);

    // State, cursor and clear counter registers.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            cnt     <= '0;
            cur_row <= '0;
            cur_col <= '0;
            o_ready <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            cur_row <= cur_row_d;
            cur_col <= cur_col_d;
            o_ready <= (state_d == IDLE);
        end
    end

    // Next-state, cursor update and RAM write-port control.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        cur_row_d = cur_row;
        cur_col_d = cur_col;
        we        = 1'b0;
        waddr     = cell_addr(32'(cur_row), 32'(cur_col));
        wdata     = ASCII_SPACE;
        unique case (state)
            CLEAR: begin
                we    = 1'b1;
                waddr = cnt;
                if (cnt == CNT_W'(CELLS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ROW_CLR: begin
                we    = 1'b1;
                waddr = cell_addr(32'(cur_row), 32'(cnt));
                if (cnt == CNT_W'(COLS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            IDLE: begin
                if (i_valid && o_ready) begin
                    if (i_char >= ASCII_SPACE && i_char <= ASCII_TILDE) begin
                        we    = 1'b1;
                        wdata = i_char;
                        if (cur_col == COL_W'(COLS - 1)) begin
                            cur_col_d = '0;
                            cur_row_d = row_inc;
                            state_d   = ROW_CLR;
                            cnt_d     = '0;
                        end else begin
                            cur_col_d = cur_col + COL_W'(1);
                        end
                    end else begin
                        case (i_char)
                            ASCII_CR, ASCII_LF: begin
                                cur_col_d = '0;
                                cur_row_d = row_inc;
                                state_d   = ROW_CLR;
                                cnt_d     = '0;
                            end
                            ASCII_BS: begin
                                if (cur_col != '0) begin
                                    cur_col_d = cur_col - COL_W'(1);
                                    we        = 1'b1;
                                    waddr     = cell_addr(32'(cur_row), 32'(cur_col) - 1);
                                end else if (cur_row != '0) begin
                                    cur_row_d = cur_row - ROW_W'(1);
                                    cur_col_d = COL_W'(COLS - 1);
                                    we        = 1'b1;
                                    waddr     = cell_addr(32'(cur_row) - 1, COLS - 1);
                                end
                            end
                            ASCII_FF: begin
                                cur_row_d = '0;
                                cur_col_d = '0;
                                state_d   = CLEAR;
                                cnt_d     = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Pixel to cell mapping; off-screen cells force a zero code.
    assign col_rd      = i_x >> GLYPH_LOG2;
    assign row_rd      = i_y >> GLYPH_LOG2;
    assign rd_in_range = (32'(col_rd) < COLS) && (32'(row_rd) < ROWS);
    assign rd_addr     = rd_in_range ? cell_addr(32'(row_rd), 32'(col_rd)) : '0;

    char_ram #(
        .DEPTH  (CELLS),
        .WIDTH  (7),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (pix_clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr  (rd_addr),
        .rd_clr (!rd_in_range),
        .rdata  (o_character)
    );

`ifdef CURSOR_BLINK_EN
    localparam int unsigned BLINK_W = width_of(BLINK_CYCLES);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    // Blink phase toggles every BLINK_CYCLES cycles.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    // Cursor flag aligned with the registered character code.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cursor <= 1'b0;
        end else begin
            o_cursor <= rd_in_range && blink_phase &&
                        (32'(row_rd) == 32'(cur_row)) &&
                        (32'(col_rd) == 32'(cur_col));
        end
    end
`else
    // Blink period only matters when the blink logic is built.
    logic unused_blink;
    assign unused_blink = ^32'(BLINK_CYCLES);
    assign o_cursor     = 1'b0;
`endif

endmodule
